lamp_seq_ctrl: RTL and testbench



---
 rtl/lamp_seq_ctrl.sv | 108 ++++++++++
 tb/tb_lamp_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_seq_ctrl.sv
// Four-colour lamp scheduler (R -> G -> Y -> B) with per-colour programmable dwell times.
// Optional fault blink (fault input, RED blinking, sequence frozen) enabled by LAMP_FAULT_BLINK_EN.
module lamp_seq_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned DWELL_R = 4,
    parameter int unsigned DWELL_G = 4,
    parameter int unsigned DWELL_Y = 2,
    parameter int unsigned DWELL_B = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
`ifdef LAMP_FAULT_BLINK_EN
    input  logic          fault,
`endif
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [DW-1:0] cfg_data,
    output logic [0:3]    light,
    output logic [1:0]    phase,
    output logic          wrap
);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] cnt;
    logic [DW-1:0] dwell [4];
    logic [DW-1:0] dwell_cur;
    logic [DW-1:0] eff;
    logic [0:3]    lamp;
    logic          at_end;
    logic          freeze;
    logic          step;

    function automatic logic [0:3] decode(input state_t s);
        logic [0:3] l;
        l = 4'b1000;
        unique case (s)
            S0: l = 4'b1000;
            S1: l = 4'b0100;
            S2: l = 4'b0010;
            S3: l = 4'b0001;
        endcase
        return l;
    endfunction

`ifdef LAMP_FAULT_BLINK_EN
    logic blink;

    assign freeze = fault;

    // Blink phase restarts at 0 each time a fault episode begins, so the first fault cycle is RED.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink <= 1'b0;
        end else begin
            blink <= fault ? ~blink : 1'b0;
        end
    end

    assign light = fault ? (blink ? 4'b0000 : 4'b1000) : lamp;
`else
    assign freeze = 1'b0;
    assign light  = lamp;
`endif

    // Zero dwell is treated as one cycle; >= lets a shrunk dwell advance at once instead of lapping.
    always_comb begin
        dwell_cur = dwell[state];
        eff       = (dwell_cur == '0) ? DW'(1) : dwell_cur;
        at_end    = (cnt >= eff - DW'(1));
        step      = run && !freeze;
        state_nxt = state_t'(state + 2'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S0;
            cnt      <= '0;
            wrap     <= 1'b0;
            lamp     <= 4'b1000;
            dwell[0] <= DW'(DWELL_R);
            dwell[1] <= DW'(DWELL_G);
            dwell[2] <= DW'(DWELL_Y);
            dwell[3] <= DW'(DWELL_B);
        end else begin
            if (cfg_we) begin
                dwell[cfg_sel] <= cfg_data;
            end
            if (step && at_end) begin
                state <= state_nxt;
                cnt   <= '0;
                lamp  <= decode(state_nxt);
                wrap  <= (state == S3);
            end else begin
                if (step) begin
                    cnt <= cnt + DW'(1);
                end
                wrap <= 1'b0;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_lamp_seq_ctrl.sv
// Self-checking bench for lamp_seq_ctrl: directed scenarios plus randomized traffic vs a colour/elapsed model.
module tb_lamp_seq_ctrl;

`ifdef LAMP_FAULT_BLINK_EN
    localparam bit HAS_FAULT = 1'b1;
`else
    localparam bit HAS_FAULT = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       run;
    logic       fault;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic [0:3] light;
    logic [1:0] phase;
    logic       wrap;

    int n_cmp;
    int n_fail;

    // Reference: colour index, cycles already spent in it, dwell table, wrap flag, blink phase.
    int m_idx;
    int m_cnt;
    int m_dw [4];
    bit m_wrap;
    bit m_blink;

    lamp_seq_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
`ifdef LAMP_FAULT_BLINK_EN
        .fault    (fault),
`endif
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .light    (light),
        .phase    (phase),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] model_out();
        logic [3:0] l;
        if (HAS_FAULT && fault) l = m_blink ? 4'b0000 : 4'b1000;
        else                    l = 4'b1000 >> m_idx;
        return {l, 2'(m_idx), m_wrap};
    endfunction

    task automatic model_edge();
        int  e;
        bit  frz;
        frz = HAS_FAULT && fault;
        if (reset) begin
            m_idx = 0; m_cnt = 0; m_wrap = 1'b0; m_blink = 1'b0;
            m_dw  = '{4, 4, 2, 2};
        end else begin
            e       = (m_dw[m_idx] == 0) ? 1 : m_dw[m_idx];
            m_blink = frz ? !m_blink : 1'b0;
            m_wrap  = 1'b0;
            if (!frz && run) begin
                if (m_cnt + 1 >= e) begin
                    m_wrap = (m_idx == 3);
                    m_idx  = (m_idx + 1) % 4;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (cfg_we) m_dw[cfg_sel] = int'(cfg_data);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; cfg_we = 1'b0; fault = 1'b0;
        settle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] seq [13];
        seq = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b1000};
        reset = 1'b1; run = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd9; fault = 1'b0;
        settle();
        tick();
        tick();
        n_cmp++;
        if ({light, phase, wrap} !== {4'b1000, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", {light, phase, wrap}, 7'b1000000);
        end
        reset = 1'b0; cfg_we = 1'b0; run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            settle();
            n_cmp++;
            if ({light, wrap} !== {seq[i], (i == 12)}) begin
                n_fail++;
                $display("FAIL reset_seq cyc=%0d got=%b exp=%b", i, {light, wrap}, {seq[i], (i == 12)});
            end
            tick();
        end
    endtask

    task automatic test_pause();
        logic [0:8] pat;
        logic [6:0] exp;
        pat = 9'b110000011;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) run = pat[i];
            settle();
            exp = (i < 9) ? {4'b1000, 2'd0, 1'b0} : {4'b0100, 2'd1, 1'b0};
            n_cmp++;
            if ({light, phase, wrap} !== exp) begin
                n_fail++;
                $display("FAIL pause cyc=%0d got=%b exp=%b", i, {light, phase, wrap}, exp);
            end
            if (i < 9) tick();
        end
    endtask

    task automatic test_zero_dwell();
        int ycount;
        ycount = 0;
        do_reset();
        run = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 8'd0;
        for (int i = 0; i < 23; i++) begin
            settle();
            n_cmp++;
            if ({light, phase, wrap} !== model_out()) begin
                n_fail++;
                $display("FAIL zero_dwell cyc=%0d got=%b exp=%b", i, {light, phase, wrap}, model_out());
            end
            if (light == 4'b0010) ycount++;
            tick();
            cfg_we = 1'b0;
        end
        n_cmp++;
        if (ycount !== 2) begin
            n_fail++;
            $display("FAIL zero_dwell_ycount got=%0d exp=%0d", ycount, 2);
        end
    endtask

    task automatic test_live_shrink();
        do_reset();
        run = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd2;
        for (int i = 0; i < 10; i++) begin
            cfg_we = (i == 5);
            settle();
            n_cmp++;
            if ({light, phase, wrap} !== model_out()) begin
                n_fail++;
                $display("FAIL live_shrink cyc=%0d got=%b exp=%b", i, {light, phase, wrap}, model_out());
            end
            if (i == 6 || i == 7) begin
                n_cmp++;
                if (light !== ((i == 6) ? 4'b0100 : 4'b0010)) begin
                    n_fail++;
                    $display("FAIL live_shrink_adv cyc=%0d got=%b exp=%b", i, light,
                             (i == 6) ? 4'b0100 : 4'b0010);
                end
            end
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_mid_reset();
        int k;
        do_reset();
        run = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd10;
        settle();
        tick();
        cfg_we = 1'b0;
        k = 0;
        while (phase != 2'd3 && k < 40) begin
            tick();
            k++;
        end
        n_cmp++;
        if (phase !== 2'd3 || k !== 15) begin
            n_fail++;
            $display("FAIL mid_reset_reach_blue got=%0d exp=%0d", k, 15);
        end
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++;
            if ({light, wrap} !== {((i < 4) ? 4'b1000 : 4'b0100), 1'b0}) begin
                n_fail++;
                $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, {light, wrap},
                         {((i < 4) ? 4'b1000 : 4'b0100), 1'b0});
            end
            tick();
        end
    endtask

    task automatic test_fault();
        logic [3:0] exp;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 15; i++) begin
            fault = (i >= 5 && i < 11);
            settle();
            if (i >= 5 && i < 11) exp = ((i - 5) % 2 == 0) ? 4'b1000 : 4'b0000;
            else if (i >= 11 && i < 14) exp = 4'b0100;
            else exp = 4'b1000 >> m_idx;
            if (i == 14) exp = 4'b0010;
            n_cmp++;
            if ({light, wrap} !== {exp, 1'b0}) begin
                n_fail++;
                $display("FAIL fault_blink cyc=%0d got=%b exp=%b", i, {light, wrap}, {exp, 1'b0});
            end
            tick();
        end
        fault = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            run      = ($urandom_range(0, 3) != 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_data = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 6));
            reset    = ($urandom_range(0, 99) == 0);
            fault    = HAS_FAULT && ($urandom_range(0, 7) == 0);
            settle();
            n_cmp++;
            if ({light, phase, wrap} !== model_out()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, {light, phase, wrap}, model_out());
            end
            tick();
        end
        reset = 1'b0; cfg_we = 1'b0; fault = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; run = 1'b0; fault = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
        m_idx = 0; m_cnt = 0; m_wrap = 1'b0; m_blink = 1'b0;
        m_dw = '{4, 4, 2, 2};
        test_reset();
        test_pause();
        test_zero_dwell();
        test_live_shrink();
        test_mid_reset();
`ifdef LAMP_FAULT_BLINK_EN
        test_fault();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
